// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage sitting between instruction memory and decode. Issues
// sequential fetch requests over a decoupled request/response port, buffers
// returned instructions together with their pc in a QUEUE_DEPTH-entry
// prefetch queue, and resolves branch/jump redirects locally by flushing the
// queue and discarding responses to fetches that were already in flight.
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched (pop count)
// and perf_flushes (taken-redirect count) outputs.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   mem_req_*               fetch request (valid/ready, address = fetch pc)
//   mem_rsp_*               in-order fetch response, at least 1 cycle after accept
//   inst_valid/inst_ready   decode handshake on the queue head
//   inst_out/inst_pc        head instruction and its pc
//   inst_pc_next            head pc + PC_STEP (link value)
//   resolve_valid, branchType, jumpInst, compare*   branch resolution inputs
//   redirect_target         pc to continue from on a taken redirect
//   redirect_taken          combinational: a redirect is applied this cycle
//   queue_count             current queue occupancy
//   perf_fetched/perf_flushes  (FETCH_PERF_EN only) event counters
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int DATA_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int QUEUE_DEPTH       = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = {DATA_WIDTH{1'b0}},
    parameter logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4)
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [DATA_WIDTH-1:0]        mem_req_addr,
    input  logic                         mem_rsp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_rsp_data,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [INSTRUCTION_WIDTH-1:0] inst_out,
    output logic [DATA_WIDTH-1:0]        inst_pc,
    output logic [DATA_WIDTH-1:0]        inst_pc_next,
    input  logic                         resolve_valid,
    input  logic [2:0]                   branchType,
    input  logic                         jumpInst,
    input  logic                         compareEquals,
    input  logic                         compareLess,
    input  logic                         compareGreater,
    input  logic                         compareLessUnsigned,
    input  logic                         compareGreaterUnsigned,
    input  logic [DATA_WIDTH-1:0]        redirect_target,
    output logic                         redirect_taken,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                  perf_fetched,
    output logic [31:0]                  perf_flushes
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0]        fetchPc_r;
    // pc of the next response that will actually be enqueued
    logic [DATA_WIDTH-1:0]        rspPc_r;
    logic [CNT_W-1:0]             count_r;
    logic [CNT_W-1:0]             outstanding_r;
    // responses still owed to fetches issued before the last redirect
    logic [CNT_W-1:0]             discard_r;
    logic [PTR_W-1:0]             head_r;
    logic [PTR_W-1:0]             tail_r;
    logic [INSTRUCTION_WIDTH-1:0] instMem_r [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]        pcMem_r   [QUEUE_DEPTH];

    logic                         branchTaken_s;
    logic                         taken_s;
    logic                         reqFire_s;
    logic                         rspFire_s;
    logic                         push_s;
    logic                         pop_s;
    logic [CNT_W:0]               inFlight_s;
    logic [CNT_W-1:0]             outstandingNext_s;

    // Branch condition decode; bge/bgeu include equality.
    always_comb begin
        branchTaken_s = 1'b0;
        case (branchType)
            3'd1:    branchTaken_s = compareEquals;
            3'd2:    branchTaken_s = ~compareEquals;
            3'd3:    branchTaken_s = compareLess;
            3'd4:    branchTaken_s = compareGreater | compareEquals;
            3'd5:    branchTaken_s = compareLessUnsigned;
            3'd6:    branchTaken_s = compareGreaterUnsigned | compareEquals;
            default: branchTaken_s = 1'b0;
        endcase
    end

    // Handshake and credit logic. Requests are only issued while every
    // outstanding fetch is guaranteed a queue slot, so responses never overflow.
    always_comb begin
        taken_s           = resolve_valid & (jumpInst | branchTaken_s);
        inFlight_s        = {1'b0, outstanding_r} + {1'b0, count_r};
        mem_req_valid     = ~reset & (inFlight_s < (CNT_W+1)'(QUEUE_DEPTH));
        reqFire_s         = mem_req_valid & mem_req_ready;
        rspFire_s         = mem_rsp_valid;
        inst_valid        = (count_r != {CNT_W{1'b0}});
        pop_s             = inst_valid & inst_ready;
        push_s            = rspFire_s & (discard_r == {CNT_W{1'b0}}) & ~taken_s;
        outstandingNext_s = outstanding_r + CNT_W'(reqFire_s) - CNT_W'(rspFire_s);
    end

    // Output views of the fetch pc and queue head.
    always_comb begin
        mem_req_addr   = fetchPc_r;
        redirect_taken = taken_s;
        inst_out       = instMem_r[head_r];
        inst_pc        = pcMem_r[head_r];
        inst_pc_next   = pcMem_r[head_r] + PC_STEP;
        queue_count    = count_r;
    end

    // Fetch pc, queue pointers, outstanding and discard bookkeeping.
    // A taken redirect overrides increment and enqueue; every fetch still in
    // flight after this edge (including one accepted now) becomes a discard.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc_r     <= RESET_PC;
            rspPc_r       <= RESET_PC;
            count_r       <= {CNT_W{1'b0}};
            outstanding_r <= {CNT_W{1'b0}};
            discard_r     <= {CNT_W{1'b0}};
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
        end else begin
            outstanding_r <= outstandingNext_s;
            if (taken_s) begin
                fetchPc_r <= redirect_target;
                rspPc_r   <= redirect_target;
                discard_r <= outstandingNext_s;
                count_r   <= {CNT_W{1'b0}};
                head_r    <= {PTR_W{1'b0}};
                tail_r    <= {PTR_W{1'b0}};
            end else begin
                if (reqFire_s) begin
                    fetchPc_r <= fetchPc_r + PC_STEP;
                end
                if (rspFire_s && (discard_r != {CNT_W{1'b0}})) begin
                    discard_r <= discard_r - CNT_W'(1);
                end
                if (push_s) begin
                    tail_r  <= tail_r + PTR_W'(1);
                    rspPc_r <= rspPc_r + PC_STEP;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_W'(1);
                end
                count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            end
        end
    end

    // Queue storage; contents are qualified by count_r so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            instMem_r[tail_r] <= mem_rsp_data;
            pcMem_r[tail_r]   <= rspPc_r;
        end
    end

`ifdef FETCH_PERF_EN
    // Event counters; a pop in a redirect cycle still counts as fetched.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_flushes <= 32'd0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop_s);
            perf_flushes <= perf_flushes + 32'(taken_s);
        end
    end
`endif

endmodule
